// File: rtl/pc_flow_unit_pkg.sv
// Shared definitions for the program-counter / flow-control slice.
//   - FSM state encoding (BOOT / RUN / STALL)
//   - default program-counter width
//   - 5-bit opcode constants emitted by the control unit
//   - pc source select encoding used between branch_resolve and the top
//   - helper to count asserted branch decodes
package pc_flow_unit_pkg;

  localparam int PC_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Opcode field of the instruction word, decoded by the control unit into
  // the is_* strobes this block consumes.
  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_LDI = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h02;
  localparam logic [4:0] OP_SUB = 5'h03;
  localparam logic [4:0] OP_CMP = 5'h04;
  localparam logic [4:0] OP_JMP = 5'h08;
  localparam logic [4:0] OP_JZ  = 5'h09;
  localparam logic [4:0] OP_JNZ = 5'h0A;
  localparam logic [4:0] OP_JG  = 5'h0B;
  localparam logic [4:0] OP_JL  = 5'h0C;

  // Next-pc source select.
  localparam logic PC_SRC_INC    = 1'b0;
  localparam logic PC_SRC_TARGET = 1'b1;

  function automatic logic [2:0] count_hot(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_flow_unit_branch_resolve.sv
// branch_resolve: combinational branch decision.
// Inputs : zero_flag, neg_flag (registered flags), is_jump, is_jz, is_jnz,
//          is_jg, is_jl (branch decodes)
// Outputs: taken         - the winning decode's condition holds
//          target_select - PC_SRC_TARGET when pc must load the jump target
//          multi_hot     - more than one branch decode asserted
// Only the highest-priority decode is evaluated:
// jump > jz > jnz > jg > jl.
module branch_resolve
  import pc_flow_unit_pkg::*;
(
  input  logic zero_flag,
  input  logic neg_flag,
  input  logic is_jump,
  input  logic is_jz,
  input  logic is_jnz,
  input  logic is_jg,
  input  logic is_jl,
  output logic taken,
  output logic target_select,
  output logic multi_hot
);

  always_comb begin
    taken = 1'b0;
    if (is_jump) begin
      taken = 1'b1;
    end else if (is_jz) begin
      taken = zero_flag;
    end else if (is_jnz) begin
      taken = !zero_flag;
    end else if (is_jg) begin
      taken = !zero_flag && !neg_flag;
    end else if (is_jl) begin
      taken = neg_flag;
    end
    target_select = taken ? PC_SRC_TARGET : PC_SRC_INC;
    multi_hot     = count_hot({is_jump, is_jz, is_jnz, is_jg, is_jl}) > 3'd1;
  end

endmodule

// File: rtl/pc_flow_unit.sv
// pc_flow_unit: program counter, condition flags and fetch flow control.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   is_jz/is_jnz/is_jg/is_jl/is_jump - branch decodes
//   flags_write, alu_zero, alu_neg   - flag update request and new values
//   jump_target           - absolute branch destination
//   imem_ready            - instruction word at pc is valid this cycle
//   pc                    - registered fetch address
//   instr_valid           - an instruction executes this cycle
//   zero_flag, neg_flag   - registered flags
//   branch_taken          - one-cycle pulse after a taken branch retires
//   ctrl_error            - one-cycle pulse after a multi-decode instruction
//   dbg_state             - current FSM state (state_e encoding)
//
// Fetch handshake: imem_ready acts as the valid of the instruction word at
// pc; this block is always ready, so an instruction executes (instr_valid)
// exactly in a RUN cycle where imem_ready=1 and reset=0. Control inputs are
// ignored in every other cycle.
module pc_flow_unit
  import pc_flow_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            is_jz,
  input  logic            is_jnz,
  input  logic            is_jg,
  input  logic            is_jl,
  input  logic            is_jump,
  input  logic            flags_write,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic [PC_W-1:0] jump_target,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic            zero_flag,
  output logic            neg_flag,
  output logic            branch_taken,
  output logic            ctrl_error,
  output logic [1:0]      dbg_state
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;
  logic            taken_q;
  logic            err_q;

  logic taken;
  logic target_select;
  logic multi_hot;

  branch_resolve u_branch_resolve (
    .zero_flag     (zero_q),
    .neg_flag      (neg_q),
    .is_jump       (is_jump),
    .is_jz         (is_jz),
    .is_jnz        (is_jnz),
    .is_jg         (is_jg),
    .is_jl         (is_jl),
    .taken         (taken),
    .target_select (target_select),
    .multi_hot     (multi_hot)
  );

  // Values committed when the current cycle executes. Branches see the old
  // flags (zero_q/neg_q) even when flags_write updates them on this edge.
  always_comb begin
    pc_d   = (target_select == PC_SRC_TARGET) ? jump_target : pc_q + PC_W'(1);
    zero_d = flags_write ? alu_zero : zero_q;
    neg_d  = flags_write ? alu_neg  : neg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Pulses drop unless this cycle executes.
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (imem_ready) begin
            pc_q    <= pc_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            taken_q <= taken;
            err_q   <= multi_hot;
          end else begin
            state_q <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (imem_ready) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign zero_flag    = zero_q;
  assign neg_flag     = neg_q;
  assign branch_taken = taken_q;
  assign ctrl_error   = err_q;
  assign instr_valid  = !reset && (state_q == ST_RUN) && imem_ready;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pc_flow_unit.sv
module tb_pc_flow_unit;
  import pc_flow_unit_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         is_jz = 0, is_jnz = 0, is_jg = 0, is_jl = 0, is_jump = 0;
  logic         flags_write = 0, alu_zero = 0, alu_neg = 0;
  logic [W-1:0] jump_target = '0;
  logic         imem_ready = 0;
  logic [W-1:0] pc;
  logic         instr_valid, zero_flag, neg_flag, branch_taken, ctrl_error;
  logic [1:0]   dbg_state;

  pc_flow_unit #(.PC_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .is_jz        (is_jz),
    .is_jnz       (is_jnz),
    .is_jg        (is_jg),
    .is_jl        (is_jl),
    .is_jump      (is_jump),
    .flags_write  (flags_write),
    .alu_zero     (alu_zero),
    .alu_neg      (alu_neg),
    .jump_target  (jump_target),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .zero_flag    (zero_flag),
    .neg_flag     (neg_flag),
    .branch_taken (branch_taken),
    .ctrl_error   (ctrl_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = boot, 1 = run, 2 = stall
  int m_mode = 0;
  int m_pc   = 0;
  bit m_zf = 0, m_nf = 0, m_bt = 0, m_ce = 0;

  // Expected {pc, zf, nf, bt, ce} after each edge.
  logic [W+3:0] exp_q[$];
  int           exp_mode_q[$];

  function automatic logic [1:0] mode_enc(input int mode);
    case (mode)
      0:       return ST_BOOT;
      1:       return ST_RUN;
      default: return ST_STALL;
    endcase
  endfunction

  task automatic model_step(input bit rst, rdy, fw, az, an, jmp, jz, jnz, jg, jl,
                            input int tgt);
    bit tk;
    int hot;
    m_bt = 0;
    m_ce = 0;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_zf = 0; m_nf = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && rdy) begin
      if (jmp)      tk = 1;
      else if (jz)  tk = m_zf;
      else if (jnz) tk = !m_zf;
      else if (jg)  tk = !m_zf && !m_nf;
      else if (jl)  tk = m_nf;
      else          tk = 0;
      hot  = int'(jmp) + int'(jz) + int'(jnz) + int'(jg) + int'(jl);
      m_pc = tk ? tgt : (m_pc + 1) % (1 << W);
      if (fw) begin
        m_zf = az;
        m_nf = an;
      end
      m_bt = tk;
      m_ce = (hot > 1);
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else begin
      if (rdy) m_mode = 1;
    end
    exp_q.push_back({W'(m_pc), m_zf, m_nf, m_bt, m_ce});
    exp_mode_q.push_back(m_mode);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, check instr_valid, step the model,
  // then check registered outputs shortly after the rising edge.
  task automatic drive(input bit rst, rdy, fw, az, an, jmp, jz, jnz, jg, jl,
                       input logic [W-1:0] tgt);
    logic [W+3:0] e;
    int           em;
    bit           exp_iv;
    @(negedge clk);
    reset = rst; imem_ready = rdy; flags_write = fw; alu_zero = az; alu_neg = an;
    is_jump = jmp; is_jz = jz; is_jnz = jnz; is_jg = jg; is_jl = jl;
    jump_target = tgt;
    #1;
    exp_iv = !rst && (m_mode == 1) && rdy;
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    model_step(rst, rdy, fw, az, an, jmp, jz, jnz, jg, jl, int'(tgt));
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    em = exp_mode_q.pop_front();
    check("pc",           32'(pc),           32'(e[W+3:4]));
    check("zero_flag",    32'(zero_flag),    32'(e[3]));
    check("neg_flag",     32'(neg_flag),     32'(e[2]));
    check("branch_taken", 32'(branch_taken), 32'(e[1]));
    check("ctrl_error",   32'(ctrl_error),   32'(e[0]));
    check("state",        32'(dbg_state),    32'(mode_enc(em)));
  endtask

  task automatic nop(input bit rdy);
    drive(0, rdy, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, with imem_ready high to show instr_valid stays low.
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h55);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_flags", 32'({zero_flag, neg_flag, branch_taken, ctrl_error}), 32'h0);

    // Reset release: BOOT then RUN; pc 0,0,1,2.
    nop(1);
    check("boot_pc", 32'(pc), 32'h0);
    nop(1);
    check("run1_pc", 32'(pc), 32'h1);
    nop(1);
    check("run2_pc", 32'(pc), 32'h2);

    // cmp sets zero, then jz taken.
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, '0);
    check("cmp_zf", 32'(zero_flag), 32'h1);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h40);
    check("jz_pc", 32'(pc), 32'h40);
    check("jz_bt", 32'(branch_taken), 32'h1);

    // Clear flags; jl not taken, jg taken.
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h20);
    check("jl_pc", 32'(pc), 32'h42);
    check("jl_bt", 32'(branch_taken), 32'h0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 8'h20);
    check("jg_pc", 32'(pc), 32'h20);

    // flags_write with a branch: branch sees old flags (zf=0 -> jz not taken).
    drive(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 8'h77);
    check("fw_jz_pc", 32'(pc), 32'h21);
    check("fw_jz_zf", 32'(zero_flag), 32'h1);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0);

    // Wrap from 0xFF to 0x00.
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'hFF);
    check("to_ff_pc", 32'(pc), 32'hFF);
    nop(1);
    check("wrap_pc", 32'(pc), 32'h00);

    // Stall for 3 cycles with jump requested: pc holds.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h10);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h10);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h10);
    check("stall_pc", 32'(pc), 32'h00);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h10);   // STALL -> RUN, no execute
    check("unstall_pc", 32'(pc), 32'h00);
    check("unstall_bt", 32'(branch_taken), 32'h0);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'h10);
    check("stall_jmp_pc", 32'(pc), 32'h10);

    // Stall again, resume without jump: plain increment.
    nop(0);
    nop(1);
    nop(1);
    check("stall_nojmp_pc", 32'(pc), 32'h11);

    // Multi-hot decode: jump wins over jz, ctrl_error pulses once.
    drive(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 8'h33);
    check("multi_pc", 32'(pc), 32'h33);
    check("multi_err", 32'(ctrl_error), 32'h1);
    nop(1);
    check("multi_err_clr", 32'(ctrl_error), 32'h0);

    // Set flags, stall, reset during stall.
    drive(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, '0);
    nop(0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h99);
    check("stall_rst_pc", 32'(pc), 32'h0);
    check("stall_rst_flags", 32'({zero_flag, neg_flag}), 32'h0);
    check("stall_rst_state", 32'(dbg_state), 32'(ST_BOOT));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0),
            W'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
